pc_gen_unit: RTL and testbench

//   Parametrised multi-thread program-counter generator; successor to the single-thread +4 PC register.

---
 rtl/pc_gen_unit_if.sv | 32 +++
 rtl/pc_gen_unit.sv | 135 +++++++++++++
 tb/tb_pc_gen_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_unit_if.sv
// ---------------------------------------------------------------------------
// pc_gen_unit_if
//   Fetch-side valid/ready handshake of the PC generator.
//   Ports (signals):
//     out_valid  fetch PC valid              (master -> slave)
//     out_ready  fetch stage accepts         (slave  -> master)
//     out_pc     fetch PC, XLEN bits         (master -> slave)
//     out_tid    thread of out_pc, TID_W     (master -> slave)
// ---------------------------------------------------------------------------
interface pc_gen_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TID_W = 1
);
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [TID_W-1:0] out_tid;

    modport master (
        output out_valid,
        output out_pc,
        output out_tid,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_tid,
        output out_ready
    );
endinterface

// File: rtl/pc_gen_unit.sv
// ---------------------------------------------------------------------------
// pc_gen_unit
//   Multi-thread program-counter generator. Keeps one PC per hardware thread
//   and issues one fetch PC per cycle, picking enabled threads round-robin,
//   through a registered valid/ready output slot. Supports per-thread branch
//   redirect, trap vectoring, thread enable and flush of the held entry.
//   Ports:
//     clk          clock, rising edge
//     rst          synchronous active-high reset
//     thread_en    per-thread issue enable
//     redir_valid  redirect request; redir_tid / redir_pc give thread and PC
//     trap_valid   trap request; trap_tid gives the trapping thread
//     fetch        output handshake (out_valid/out_ready/out_pc/out_tid)
// ---------------------------------------------------------------------------
module pc_gen_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     INC         = 4,
    parameter int unsigned     NUM_THREADS = 2,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h100),
    parameter int unsigned     TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic                   redir_valid,
    input  logic [TID_W-1:0]       redir_tid,
    input  logic [XLEN-1:0]        redir_pc,
    input  logic                   trap_valid,
    input  logic [TID_W-1:0]       trap_tid,
    pc_gen_unit_if.master          fetch
);

    localparam logic [XLEN-1:0]  INC_V    = XLEN'(INC);
    localparam logic [XLEN-1:0]  LOW_MASK = XLEN'(INC - 1);
    localparam logic [TID_W:0]   NT       = (TID_W + 1)'(NUM_THREADS);
    localparam logic [TID_W-1:0] PTR_RST  = TID_W'(NUM_THREADS - 1);

    logic [XLEN-1:0]  pc_q [NUM_THREADS];
    logic [XLEN-1:0]  pc_d [NUM_THREADS];
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  opc_q, opc_d;
    logic [TID_W-1:0] otid_q, otid_d;
    logic [TID_W-1:0] ptr_q, ptr_d;

    logic             redir_hit, trap_hit, redir_take;
    logic             flush, free, load;
    logic [TID_W-1:0] sel;
    logic [XLEN-1:0]  sel_pc;

    // Out-of-range thread ids are ignored completely.
    assign redir_hit  = redir_valid && ({1'b0, redir_tid} < NT);
    assign trap_hit   = trap_valid && ({1'b0, trap_tid} < NT);
    // Trap beats a redirect aimed at the same thread.
    assign redir_take = redir_hit && !(trap_hit && (trap_tid == redir_tid));

    assign flush = valid_q && ((trap_hit && (trap_tid == otid_q)) ||
                               (redir_take && (redir_tid == otid_q)));
    assign free  = !valid_q || fetch.out_ready;
    // Any valid redirect/trap costs one bubble cycle.
    assign load  = free && (|thread_en) && !redir_hit && !trap_hit;

    // Round-robin pick: the enabled thread at the smallest distance past ptr.
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        best_d = NUM_THREADS;
        d      = 0;
        sel    = ptr_q;
        sel_pc = pc_q[0];
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            d = (t + NUM_THREADS - 32'(ptr_q) - 1) % NUM_THREADS;
            if (thread_en[t] && (d < best_d)) begin
                best_d = d;
                sel    = TID_W'(t);
                sel_pc = pc_q[t];
            end
        end
    end

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        opc_d   = opc_q;
        otid_d  = otid_q;
        ptr_d   = ptr_q;

        // Load and redirect/trap are mutually exclusive, so order is irrelevant.
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (load && (sel == TID_W'(t))) begin
                pc_d[t] = pc_q[t] + INC_V;
            end
            if (redir_take && (redir_tid == TID_W'(t))) begin
                pc_d[t] = redir_pc & ~LOW_MASK;
            end
            if (trap_hit && (trap_tid == TID_W'(t))) begin
                pc_d[t] = TRAP_VEC;
            end
        end

        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            opc_d   = sel_pc;
            otid_d  = sel;
            ptr_d   = sel;
        end else if (free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= RESET_VEC;
            end
            valid_q <= 1'b0;
            opc_q   <= '0;
            otid_q  <= '0;
            ptr_q   <= PTR_RST;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            otid_q  <= otid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign fetch.out_valid = valid_q;
    assign fetch.out_pc    = opc_q;
    assign fetch.out_tid   = otid_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_gen_unit
//   Bench for pc_gen_unit. Instance A is single-thread (directed sequences),
//   instance B has three threads so that tid 3 is out of range; B is also
//   driven randomly against a behavioural model.
// ---------------------------------------------------------------------------
module tb_pc_gen_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Single-thread instance
    logic        a_rst, a_rv, a_tv;
    logic [0:0]  a_en, a_rtid, a_ttid;
    logic [31:0] a_rpc;
    pc_gen_unit_if #(.XLEN(32), .TID_W(1)) if_a ();
    pc_gen_unit #(.NUM_THREADS(1)) u_dut_a (
        .clk        (clk),
        .rst        (a_rst),
        .thread_en  (a_en),
        .redir_valid(a_rv),
        .redir_tid  (a_rtid),
        .redir_pc   (a_rpc),
        .trap_valid (a_tv),
        .trap_tid   (a_ttid),
        .fetch      (if_a)
    );

    // Three-thread instance
    logic        b_rst, b_rv, b_tv;
    logic [2:0]  b_en;
    logic [1:0]  b_rtid, b_ttid;
    logic [31:0] b_rpc;
    pc_gen_unit_if #(.XLEN(32), .TID_W(2)) if_b ();
    pc_gen_unit #(.NUM_THREADS(3)) u_dut_b (
        .clk        (clk),
        .rst        (b_rst),
        .thread_en  (b_en),
        .redir_valid(b_rv),
        .redir_tid  (b_rtid),
        .redir_pc   (b_rpc),
        .trap_valid (b_tv),
        .trap_tid   (b_ttid),
        .fetch      (if_b)
    );

    // Behavioural model of instance B
    logic [31:0] m_pc [3];
    bit          m_v;
    logic [31:0] m_opc;
    int          m_otid;
    int          m_ptr;

    task automatic model_step(input bit rst, input logic [2:0] en, input bit rv, input int rt,
                              input logic [31:0] rpc, input bit tv, input int tt, input bit rdy);
        bit r_ok, t_ok, free, flush, load;
        int sel;
        if (rst) begin
            for (int i = 0; i < 3; i++) m_pc[i] = 32'h0;
            m_v = 0; m_opc = 32'h0; m_otid = 0; m_ptr = 2;
            return;
        end
        t_ok  = tv && (tt < 3);
        r_ok  = rv && (rt < 3) && !(t_ok && tt == rt);
        free  = !m_v || rdy;
        flush = m_v && ((t_ok && tt == m_otid) || (r_ok && rt == m_otid));
        load  = free && (en != 3'b000) && !t_ok && !(rv && rt < 3);
        if (flush) begin
            m_v = 0;
        end else if (load) begin
            sel = -1;
            for (int k = 1; k <= 3; k++) begin
                if (sel < 0 && en[(m_ptr + k) % 3]) sel = (m_ptr + k) % 3;
            end
            m_opc = m_pc[sel];
            m_pc[sel] = m_pc[sel] + 32'd4;
            m_otid = sel;
            m_v = 1;
            m_ptr = sel;
        end else if (free) begin
            m_v = 0;
        end
        if (r_ok) m_pc[rt] = rpc & ~32'd3;
        if (t_ok) m_pc[tt] = 32'h100;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of B, advance the model alongside
    task automatic b_cycle(input bit rst, input logic [2:0] en, input bit rv, input int rt,
                           input logic [31:0] rpc, input bit tv, input int tt, input bit rdy);
        b_rst = rst; b_en = en; b_rv = rv; b_rtid = 2'(rt); b_rpc = rpc;
        b_tv = tv; b_ttid = 2'(tt); if_b.out_ready = rdy;
        model_step(rst, en, rv, rt, rpc, tv, tt, rdy);
        tick();
    endtask

    task automatic test_reset();
        a_rst = 1; a_en = 1'b1; if_a.out_ready = 1;
        tick();
        n_checks++;
        if (if_a.out_valid !== 1'b0 || if_a.out_pc !== 32'h0 || if_a.out_tid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got v=%0b pc=%h tid=%0d, expected v=0 pc=0 tid=0",
                     if_a.out_valid, if_a.out_pc, if_a.out_tid);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
        a_rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (if_a.out_valid !== 1'b1 || if_a.out_pc !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL seq[%0d]: got v=%0b pc=%h, expected v=1 pc=%h",
                         i, if_a.out_valid, if_a.out_pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_hold();
        if_a.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (if_a.out_valid !== 1'b1 || if_a.out_pc !== 32'h8) begin
                n_fail++;
                $display("FAIL hold[%0d]: got v=%0b pc=%h, expected v=1 pc=00000008",
                         i, if_a.out_valid, if_a.out_pc);
            end
        end
        if_a.out_ready = 1;
        tick();
        n_checks++;
        if (if_a.out_valid !== 1'b1 || if_a.out_pc !== 32'hC) begin
            n_fail++;
            $display("FAIL hold_release: got v=%0b pc=%h, expected v=1 pc=0000000c",
                     if_a.out_valid, if_a.out_pc);
        end
    endtask

    task automatic test_redirect_wrap();
        logic [31:0] exp_pc [3];
        a_rv = 1; a_rtid = 1'b0; a_rpc = 32'hFFFF_FFF8;
        tick();
        a_rv = 0;
        n_checks++;
        if (if_a.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_flush1: got v=%0b, expected v=0", if_a.out_valid);
        end
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (if_a.out_valid !== 1'b1 || if_a.out_pc !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got v=%0b pc=%h, expected v=1 pc=%h",
                         i, if_a.out_valid, if_a.out_pc, exp_pc[i]);
            end
        end
        a_rv = 1; a_rtid = 1'b0; a_rpc = 32'h1003;
        tick();
        a_rv = 0;
        n_checks++;
        if (if_a.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_flush2: got v=%0b, expected v=0", if_a.out_valid);
        end
        exp_pc[0] = 32'h1000; exp_pc[1] = 32'h1004;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (if_a.out_valid !== 1'b1 || if_a.out_pc !== exp_pc[i]) begin
                n_fail++;
                $display("FAIL redir_target[%0d]: got v=%0b pc=%h, expected v=1 pc=%h",
                         i, if_a.out_valid, if_a.out_pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_trap_priority();
        a_tv = 1; a_ttid = 1'b0; a_rv = 1; a_rtid = 1'b0; a_rpc = 32'h2000;
        tick();
        a_tv = 0; a_rv = 0;
        n_checks++;
        if (if_a.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_flush: got v=%0b, expected v=0", if_a.out_valid);
        end
        tick();
        n_checks++;
        if (if_a.out_valid !== 1'b1 || if_a.out_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL trap_vec: got v=%0b pc=%h, expected v=1 pc=00000100",
                     if_a.out_valid, if_a.out_pc);
        end
        tick();
        n_checks++;
        if (if_a.out_valid !== 1'b1 || if_a.out_pc !== 32'h104) begin
            n_fail++;
            $display("FAIL trap_next: got v=%0b pc=%h, expected v=1 pc=00000104",
                     if_a.out_valid, if_a.out_pc);
        end
    endtask

    task automatic test_reset_during_hold();
        if_a.out_ready = 0;
        tick();
        n_checks++;
        if (if_a.out_valid !== 1'b1 || if_a.out_pc !== 32'h104) begin
            n_fail++;
            $display("FAIL pre_rst_hold: got v=%0b pc=%h, expected v=1 pc=00000104",
                     if_a.out_valid, if_a.out_pc);
        end
        a_rst = 1;
        tick();
        a_rst = 0; if_a.out_ready = 1;
        n_checks++;
        if (if_a.out_valid !== 1'b0 || if_a.out_pc !== 32'h0 || if_a.out_tid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_hold: got v=%0b pc=%h tid=%0d, expected v=0 pc=0 tid=0",
                     if_a.out_valid, if_a.out_pc, if_a.out_tid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (if_a.out_valid !== 1'b1 || if_a.out_pc !== 32'(i * 4)) begin
                n_fail++;
                $display("FAIL restart[%0d]: got v=%0b pc=%h, expected v=1 pc=%h",
                         i, if_a.out_valid, if_a.out_pc, 32'(i * 4));
            end
        end
    endtask

    task automatic test_round_robin();
        int          exp_tid [6];
        logic [31:0] exp_pc  [6];
        exp_tid[0] = 0; exp_tid[1] = 1; exp_tid[2] = 0; exp_tid[3] = 1;
        exp_tid[4] = 0; exp_tid[5] = 0;
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h0; exp_pc[2] = 32'h4; exp_pc[3] = 32'h4;
        exp_pc[4] = 32'h8; exp_pc[5] = 32'hC;
        b_cycle(1, 3'b011, 0, 0, 32'h0, 0, 0, 1);
        n_checks++;
        if (if_b.out_valid !== 1'b0 || if_b.out_pc !== 32'h0 || if_b.out_tid !== 2'd0) begin
            n_fail++;
            $display("FAIL rr_reset: got v=%0b pc=%h tid=%0d, expected v=0 pc=0 tid=0",
                     if_b.out_valid, if_b.out_pc, if_b.out_tid);
        end
        for (int i = 0; i < 6; i++) begin
            b_cycle(0, (i < 4) ? 3'b011 : 3'b001, 0, 0, 32'h0, 0, 0, 1);
            n_checks++;
            if (if_b.out_valid !== 1'b1 || if_b.out_pc !== exp_pc[i] ||
                int'(if_b.out_tid) != exp_tid[i]) begin
                n_fail++;
                $display("FAIL rr[%0d]: got v=%0b pc=%h tid=%0d, expected v=1 pc=%h tid=%0d",
                         i, if_b.out_valid, if_b.out_pc, if_b.out_tid, exp_pc[i], exp_tid[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        b_cycle(1, 3'b111, 0, 0, 32'h0, 0, 0, 0);
        b_cycle(0, 3'b111, 0, 0, 32'h0, 0, 0, 0);
        // Held entry tid0; tid 3 redirect+trap must not touch it
        b_cycle(0, 3'b111, 1, 3, 32'h5000, 1, 3, 0);
        n_checks++;
        if (if_b.out_valid !== 1'b1 || if_b.out_pc !== 32'h0 || if_b.out_tid !== 2'd0) begin
            n_fail++;
            $display("FAIL oor_hold: got v=%0b pc=%h tid=%0d, expected v=1 pc=0 tid=0",
                     if_b.out_valid, if_b.out_pc, if_b.out_tid);
        end
        for (int i = 0; i < 4; i++) begin
            b_cycle(0, 3'b111, 1, 3, 32'h5000, 0, 0, 1);
            n_checks++;
            if (if_b.out_valid !== m_v || if_b.out_pc !== m_opc || int'(if_b.out_tid) != m_otid)
            begin
                n_fail++;
                $display("FAIL oor_issue[%0d]: got v=%0b pc=%h tid=%0d, expected v=%0b pc=%h tid=%0d",
                         i, if_b.out_valid, if_b.out_pc, if_b.out_tid, m_v, m_opc, m_otid);
            end
        end
    endtask

    task automatic test_random();
        bit          rst, rv, tv, rdy;
        logic [2:0]  en;
        int          rt, tt;
        logic [31:0] rpc;
        b_cycle(1, 3'b111, 0, 0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(59, 0) == 0);
            en  = ($urandom_range(7, 0) == 0) ? 3'b000 : 3'($urandom);
            rv  = ($urandom_range(5, 0) == 0);
            tv  = ($urandom_range(7, 0) == 0);
            rt  = $urandom_range(3, 0);
            tt  = $urandom_range(3, 0);
            rdy = ($urandom_range(3, 0) != 0);
            rpc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : $urandom;
            b_cycle(rst, en, rv, rt, rpc, tv, tt, rdy);
            n_checks++;
            if (if_b.out_valid !== m_v || if_b.out_pc !== m_opc || int'(if_b.out_tid) != m_otid)
            begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%0b pc=%h tid=%0d, expected v=%0b pc=%h tid=%0d",
                         i, if_b.out_valid, if_b.out_pc, if_b.out_tid, m_v, m_opc, m_otid);
            end
        end
    endtask

    initial begin
        a_rst = 1; a_en = 1'b1; a_rv = 0; a_tv = 0; a_rtid = 1'b0; a_ttid = 1'b0; a_rpc = 32'h0;
        if_a.out_ready = 0;
        b_rst = 1; b_en = 3'b000; b_rv = 0; b_tv = 0; b_rtid = 2'd0; b_ttid = 2'd0;
        b_rpc = 32'h0;
        if_b.out_ready = 0;

        test_reset();
        test_sequential();
        test_hold();
        test_redirect_wrap();
        test_trap_priority();
        test_reset_during_hold();
        test_round_robin();
        test_out_of_range();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
